uart_fifo: RTL
==============

# uart_fifo

Parametrised synchronous FIFO for the UART datapath, replacing the fixed 4-entry TX FIFO. It adds fill-level reporting, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. It also defines simultaneous read/write at the full and empty boundaries. It sits between the host-side producer and the UART transmitter, and can be instantiated as an RX FIFO with no change.

## Interface
Parameters:
- DATA_SIZE, 8, word width in bits (≥1)
- ADDR_SPACE_EXP, 4, log2 of depth; DEPTH = 2**ADDR_SPACE_EXP (≥1)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- ckht  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request, level-sampled each cycle
- rd  in  1  read request (pop), level-sampled each cycle
- flush  in  1  synchronous clear of FIFO contents and error flags
- wr_data  in  DATA_SIZE  word to write
- rd_data  out  DATA_SIZE  head-of-queue word (first-word-fall-through)
- count  out  ADDR_SPACE_EXP+1  number of stored words, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accepted iff wr & ~full. Word is stored at wr_ptr and wr_ptr advances.
- Read accepted iff rd & ~empty. rd_ptr advances and the next word appears on rd_data.
- Acceptance depends only on registered flags. There is no combinational path from rd to write acceptance.
- Pointers are ADDR_SPACE_EXP bits and wrap modulo DEPTH. count is a separate up/down counter.
- Both requests, 0 < count < DEPTH: both accepted and count unchanged.
- Both requests when empty: write accepted, read rejected, underflow set, count becomes 1.
- Both requests when full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
- wr while full (read or not): word dropped, memory unchanged, overflow ← 1.
- rd while empty: no pointer change, underflow ← 1.
- overflow and underflow stay set until flush or reset.
- flush has priority over rd and wr in the same cycle:
  - pointers, count and both error flags are cleared;
  - empty ← 1, full ← 0;
  - almost flags are recomputed for count 0;
  - memory contents are not cleared.
- rd_data = mem[rd_ptr], combinational from registered state. It is valid only while ~empty; when empty its value is unspecified except directly after reset.
- Reset values:
  - count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0;
  - memory cleared to 0, so rd_data = 0.
- Reset asserted mid-operation immediately forces the reset values asynchronously. Any in-flight request is lost.

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N is on rd_data after edge N if the FIFO was empty, and empty deasserts after edge N.
- Read latency is 0 cycles. rd_data already holds the head. After a pop at edge N, the next word is on rd_data after edge N.
- All flags and count are registered and computed from next-state count. They are valid one edge after the causing request, with no further lag.
- A request held for K cycles produces K accepted operations, subject to the flags.
- Throughput is one write and one read per cycle.

## Structure
- Package uart_fifo_pkg holds:
  - default constants UART_DATA_SIZE = 8 and UART_FIFO_ADDR_EXP = 4;
  - typedef fifo_status_t, a packed struct {empty, full, almost_empty, almost_full, overflow, underflow}, for status aggregation in the UART top.
- Sub-module fifo_regfile holds the memory: DATA_SIZE × DEPTH flops with an async-clear write port and a combinational read port. Control, pointers, count and flags live in uart_fifo.
- Elaboration-time assertions check the parameter ranges: AE_LEVEL < AF_LEVEL, and both levels within the ranges given under Parameters.

## Test plan
- Reset and fill: release rst_n, then write 0x11..0x1F and 0x20 (16 words, DEPTH=16).
  - After reset: empty=1, count=0, rd_data=0.
  - almost_full rises when count reaches 15 (0x1F written); full=1 with count=16 after 0x20.
  - A 17th write leaves count at 16 and sets overflow.
- Drain with wrap: pre-load pointers to 14, then write 0xA0..0xA3 and read them back.
  - rd_data reads 0xA0, 0xA1, 0xA2, 0xA3 in order across the pointer wrap.
  - empty=1 after the 4th pop.
- Simultaneous read/write:
  - At count=5: count stays 5 and data order is preserved.
  - When empty: count becomes 1, rd_data holds the written word, underflow=1.
  - When full: count becomes 15, overflow=1.
- Flush: at count=9 with overflow=1, pulse flush together with wr=1.
  - Next cycle: count=0, empty=1, overflow=0; the concurrent write is discarded.
- Thresholds: AE_LEVEL=2, AF_LEVEL=12. Step count 0→13→0 one word at a time.
  - almost_empty is high exactly for count ≤ 2; almost_full is high exactly for count ≥ 12.
- Mid-operation reset: assert rst_n low between edges during a burst.
  - All outputs take their reset values immediately.
  - After release, a write of 0x5A is read back as 0x5A.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared constants and status types for the UART FIFO and the UART top level.
package uart_fifo_pkg;

   localparam int UART_DATA_SIZE     = 8;
   localparam int UART_FIFO_ADDR_EXP = 4;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one write port with async clear, one combinational read port.
module fifo_regfile
   import uart_fifo_pkg::*;
#(
   parameter int DATA_SIZE = UART_DATA_SIZE,
   parameter int ADDR_EXP  = UART_FIFO_ADDR_EXP
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [ADDR_EXP-1:0]  waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic [ADDR_EXP-1:0]  raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_EXP;

   logic [DATA_SIZE-1:0] mem [DEPTH];

   // Storage array; cleared on reset so the head reads zero straight after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end else begin
         mem[waddr] <= mem[waddr];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// Parametrised synchronous FWFT FIFO with fill level, threshold flags,
// sticky error flags and synchronous flush.
module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DATA_SIZE      = UART_DATA_SIZE,
   parameter int ADDR_SPACE_EXP = UART_FIFO_ADDR_EXP,
   parameter int AF_LEVEL       = (2 ** ADDR_SPACE_EXP) - 1,
   parameter int AE_LEVEL       = 1
) (
   input  logic                      ckht,
   input  logic                      rst_n,
   input  logic                      wr,
   input  logic                      rd,
   input  logic                      flush,
   input  logic [DATA_SIZE-1:0]      wr_data,
   output logic [DATA_SIZE-1:0]      rd_data,
   output logic [ADDR_SPACE_EXP:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int DEPTH = 2 ** ADDR_SPACE_EXP;
   localparam int AW    = ADDR_SPACE_EXP;
   localparam int CW    = ADDR_SPACE_EXP + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   generate
      if (DATA_SIZE < 1 || ADDR_SPACE_EXP < 1) begin : g_bad_size
         $error("uart_fifo: DATA_SIZE and ADDR_SPACE_EXP must be >= 1");
      end
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1
          || AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
         $error("uart_fifo: AE_LEVEL/AF_LEVEL out of range or not AE_LEVEL < AF_LEVEL");
      end
   endgenerate

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_next;
   logic          wr_ok;
   logic          rd_ok;
   logic          mem_we;

   // Acceptance uses only the registered flags, so rd never gates a write.
   always_comb begin
      wr_ok      = wr & ~full;
      rd_ok      = rd & ~empty;
      mem_we     = 1'b0;
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else begin
         mem_we = wr_ok;
         case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
         endcase
      end
   end

   // Pointers, level and flags; every flag derives from the next-state count.
   always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            wr_ptr    <= wr_ok ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr    <= rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
            overflow  <= overflow | (wr & full);
            underflow <= underflow | (rd & empty);
         end
         count        <= count_next;
         empty        <= (count_next == '0);
         full         <= (count_next == DEPTH_C);
         almost_empty <= (count_next <= AE_C);
         almost_full  <= (count_next >= AF_C);
      end
   end

   fifo_regfile #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_EXP  (AW)
   ) u_regfile (
      .clk   (ckht),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule
